// File: rtl/vxe_txnreqa_queue.sv
// In-order request-address queue; splits head entry onto read or write address channel by rnw.
// Latency: one cycle push-to-output; backpressure: o_req_rdy drops when full, head-of-line blocks on the active channel's ready.
module vxe_txnreqa_queue #(
  parameter int DEPTH_POW2 = 2
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [43:0]           i_req_vec_txn,
  input  logic                  i_req_valid,
  output logic                  o_req_rdy,
  output logic [5:0]            o_rd_txnid,
  output logic [39:0]           o_rd_addr,
  output logic                  o_rd_valid,
  input  logic                  i_rd_rdy,
  output logic [5:0]            o_wr_txnid,
  output logic [39:0]           o_wr_addr,
  output logic                  o_wr_valid,
  input  logic                  i_wr_rdy,
  output logic [DEPTH_POW2:0]   o_count,
  output logic                  o_busy
);

  localparam int DEPTH = 1 << DEPTH_POW2;
  localparam logic [DEPTH_POW2-1:0] PTR_ONE  = DEPTH_POW2'(1);
  localparam logic [DEPTH_POW2:0]   CNT_ONE  = (DEPTH_POW2+1)'(1);
  localparam logic [DEPTH_POW2:0]   CNT_FULL = (DEPTH_POW2+1)'(DEPTH);

  logic [43:0]           r_mem [DEPTH];
  logic [DEPTH_POW2-1:0] r_wptr;
  logic [DEPTH_POW2-1:0] r_rptr;
  logic [DEPTH_POW2:0]   r_count;

  logic [43:0] w_head;
  logic        w_busy;
  logic        w_push;
  logic        w_pop;

  assign w_head = r_mem[r_rptr];
  assign w_busy = (r_count != '0);

  // Ready looks only at registered occupancy: a same-cycle pop never frees a slot early.
  assign o_req_rdy  = (r_count != CNT_FULL);
  assign o_rd_valid = w_busy && w_head[37];
  assign o_wr_valid = w_busy && !w_head[37];
  assign o_rd_txnid = w_head[43:38];
  assign o_wr_txnid = w_head[43:38];
  assign o_rd_addr  = {w_head[36:0], 3'b000};
  assign o_wr_addr  = {w_head[36:0], 3'b000};
  assign o_count    = r_count;
  assign o_busy     = w_busy;

  assign w_push = i_req_valid && o_req_rdy;
  assign w_pop  = (o_rd_valid && i_rd_rdy) || (o_wr_valid && i_wr_rdy);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_req_vec_txn;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: doc/vxe_txnreqa_queue.md
# vxe_txnreqa_queue

Request-address queue sitting directly downstream of the request transaction coder. Buffers coded 44-bit address request vectors `{txnid[5:0], rnw, addr[36:0]}` in a small in-order FIFO. Decodes the head entry and presents it on either the read-address or the write-address output channel, selected by `rnw`. Strict request order is preserved across both channels; this is the point where read/write address traffic splits before the memory bus master.

## Interface
- `DEPTH_POW2`, 2, log2 of queue depth (default 4 entries); legal 1..4
- `clk`  in  1  clock; all state on rising edge
- `nrst`  in  1  synchronous, active-low reset
- `i_req_vec_txn`  in  44  coded request: [43:38] txnid, [37] rnw (1 = read), [36:0] address bits [39:3]
- `i_req_valid`  in  1  request vector valid
- `o_req_rdy`  out  1  queue can accept a request this cycle
- `o_rd_txnid`  out  6  read request transaction id
- `o_rd_addr`  out  40  read byte address, `{addr[36:0], 3'b000}`
- `o_rd_valid`  out  1  read request valid
- `i_rd_rdy`  in  1  read channel accepts
- `o_wr_txnid`  out  6  write request transaction id
- `o_wr_addr`  out  40  write byte address, `{addr[36:0], 3'b000}`
- `o_wr_valid`  out  1  write request valid
- `i_wr_rdy`  in  1  write channel accepts
- `o_count`  out  DEPTH_POW2+1  number of occupied entries
- `o_busy`  out  1  queue non-empty

## Operation
- Storage: `2**DEPTH_POW2` entries × 44 bits; write pointer, read pointer (DEPTH_POW2 bits, natural wrap-around), occupancy counter (DEPTH_POW2+1 bits).
- Push: `i_req_valid && o_req_rdy`; entry written at write pointer, pointer +1.
- `o_req_rdy = (count != DEPTH)`. Depends only on registered state; not raised by a same-cycle pop (no full-bypass).
- Head decode: `o_rd_valid = busy && head.rnw`; `o_wr_valid = busy && !head.rnw`. At most one is high in any cycle. Both channels carry head txnid and address; the inactive channel's data is don't-care but driven from head (no X).
- Pop: `(o_rd_valid && i_rd_rdy) || (o_wr_valid && i_wr_rdy)`; read pointer +1.
- A ready on the inactive channel has no effect. A head entry blocks later entries of the other type (in-order head-of-line).
- Simultaneous push and pop: count unchanged, both pointers advance. Legal when empty only if no pop exists (pop impossible when empty); when full, push is blocked.
- Count update: +1 on push only, −1 on pop only, unchanged otherwise. Never over- or underflows.
- `o_busy = (count != 0)`.
- Valid handshake rule on outputs: once a valid is high it holds with stable txnid/addr until popped (guaranteed by FIFO structure).
- Reset (`nrst` low at a rising edge): pointers and count to 0, all queued entries discarded, including mid-handshake ones. Storage contents are not reset.

## Timing
- Reset values: `o_req_rdy` = 1, `o_rd_valid` = 0, `o_wr_valid` = 0, `o_count` = 0, `o_busy` = 0. txnid/addr outputs are don't-care while valids are low.
- Latency: a request pushed at edge N appears on the output channel after edge N (visible in cycle N+1); no combinational input-to-output path.
- Throughput: one push and one pop per cycle sustained.
- `o_req_rdy`, valids, and count are functions of registered state only; there is no combinational path from `i_rd_rdy`/`i_wr_rdy` to `o_req_rdy`.

## Test plan
- Reset then idle: `nrst` low 2 cycles -> `o_req_rdy`=1, both valids 0, `o_count`=0, `o_busy`=0.
- Single read: push `{6'h05,1'b1,37'h0_0000_0010}` with `i_rd_rdy`=1 -> next cycle `o_rd_valid`=1, `o_rd_txnid`=5, `o_rd_addr`=40'h80, `o_wr_valid`=0; popped, count back to 0.
- Ordering/blocking: push W(id 1), R(id 2), W(id 3) with `i_rd_rdy`=1, `i_wr_rdy`=0 for 5 cycles -> `o_wr_valid`=1, id 1 held stable, count 3, R not issued; raise `i_wr_rdy` -> pops in order 1, 2, 3 on the correct channels.
- Full: DEPTH_POW2=2, 4 pushes, no ready -> `o_req_rdy`=0, count 4; 5th valid ignored; one pop plus an offered push in the same cycle -> push not accepted, count 3, rdy=1 next cycle.
- Streaming/wrap: 20 back-to-back alternating R/W pushes with both readies high -> one pop per cycle, pointers wrap, count stays ≤ 1, all ids out in order with addr = in_addr<<3.
- Reset mid-operation: 3 entries queued, `nrst` low 1 cycle -> valids 0, count 0, rdy 1; old entries never reappear.
